// File: rtl/axis_pattern_gen.sv
// axis_pattern_gen: AXI-Stream source emitting packets of incrementing words.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   enable           level start/continue request
//   pkt_len          beats per packet (0 behaves as 1), latched at start
//   gap_len          idle cycles between packets, latched at start
//   num_pkts         packets per run (0 = run until enable drops), latched at start
//   m_axis_tdata     word counter, zero-extended
//   m_axis_tvalid    beat valid (SEND state only)
//   m_axis_tlast     last beat of packet
//   m_axis_tready    sink ready
//   busy             high whenever not IDLE
//   done             one-cycle pulse after num_pkts packets
//   pkt_count        packets completed since the last start
module axis_pattern_gen #(
    parameter int DATAWIDTH = 64,
    parameter int LENWIDTH  = 16,
    parameter int GAPWIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [LENWIDTH-1:0]  pkt_len,
    input  logic [GAPWIDTH-1:0]  gap_len,
    input  logic [15:0]          num_pkts,
    output logic [DATAWIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          pkt_count
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [DATAWIDTH-1:0] word_q, word_d;
    logic [LENWIDTH-1:0]  beat_q, beat_d;
    logic [GAPWIDTH-1:0]  gap_q, gap_d;
    logic [LENWIDTH-1:0]  len_q, len_d;
    logic [GAPWIDTH-1:0]  glen_q, glen_d;
    logic [15:0]          npkts_q, npkts_d;
    logic [15:0]          pkt_count_q, pkt_count_d;

    logic xfer;
    logic last_beat;

    // tvalid depends only on registered state, so tready never reaches it
    // combinationally; data and tlast hold while stalled because the
    // counters only move on a transfer.
    assign m_axis_tvalid = (state_q == S_SEND);
    assign m_axis_tdata  = word_q;
    assign last_beat     = (beat_q == len_q - LENWIDTH'(1));
    assign m_axis_tlast  = m_axis_tvalid && last_beat;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign pkt_count     = pkt_count_q;
    assign xfer          = m_axis_tvalid && m_axis_tready;

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        beat_d      = beat_q;
        gap_d       = gap_q;
        len_d       = len_q;
        glen_d      = glen_q;
        npkts_d     = npkts_q;
        pkt_count_d = pkt_count_q;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    len_d       = (pkt_len == '0) ? LENWIDTH'(1) : pkt_len;
                    glen_d      = gap_len;
                    npkts_d     = num_pkts;
                    pkt_count_d = '0;
                    word_d      = '0;
                    beat_d      = '0;
                    gap_d       = '0;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    word_d = word_q + DATAWIDTH'(1);
                    if (last_beat) begin
                        beat_d      = '0;
                        pkt_count_d = pkt_count_q + 16'd1;
                        gap_d       = '0;
                        // Run completion wins over enable; enable only
                        // stops the stream at a packet boundary.
                        if (npkts_q != 16'd0 && (pkt_count_q + 16'd1) == npkts_q)
                            state_d = S_DONE;
                        else if (!enable)
                            state_d = S_IDLE;
                        else if (glen_q != '0)
                            state_d = S_GAP;
                        else
                            state_d = S_SEND;
                    end else begin
                        beat_d = beat_q + LENWIDTH'(1);
                    end
                end
            end
            S_GAP: begin
                // Entered with gap_q = 0; leaves after exactly glen_q cycles.
                if (gap_q == glen_q - GAPWIDTH'(1)) begin
                    gap_d   = '0;
                    state_d = enable ? S_SEND : S_IDLE;
                end else begin
                    gap_d = gap_q + GAPWIDTH'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            beat_q      <= '0;
            gap_q       <= '0;
            len_q       <= '0;
            glen_q      <= '0;
            npkts_q     <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            beat_q      <= beat_d;
            gap_q       <= gap_d;
            len_q       <= len_d;
            glen_q      <= glen_d;
            npkts_q     <= npkts_d;
            pkt_count_q <= pkt_count_d;
        end
    end

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Bench for axis_pattern_gen: table of directed runs, randomized runs with
// random back-pressure checked against an arithmetic stream model, and a
// hand-written mid-packet reset sequence.
module tb_axis_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] pkt_len;
    logic [7:0]  gap_len;
    logic [15:0] num_pkts;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        busy;
    logic        done;
    logic [15:0] pkt_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axis_pattern_gen #(.DATAWIDTH(64), .LENWIDTH(16), .GAPWIDTH(8)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .pkt_len(pkt_len), .gap_len(gap_len), .num_pkts(num_pkts),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .busy(busy), .done(done), .pkt_count(pkt_count)
    );

    typedef struct {
        int len;
        int gap;
        int n;
        int rnd;
        int drop_at;
        int exp_words;
        int exp_pkts;
        int exp_done;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One run from IDLE: start, drive tready (random or always 1), and check
    // every beat against the stream model: word k is k, tlast iff k is the
    // last beat of its packet, exactly gap idle cycles between packets, and
    // a stalled beat holds its data.
    task automatic run_case(input int len, input int gap, input int n, input int rnd,
                            input int drop_at, output int words, output int pkts,
                            output int dones);
        int          lw;
        int          k;
        int          cyc;
        int          lowrun;
        bit          prev_stall;
        logic [63:0] prev_data;
        logic        prev_last;
        lw = (len == 0) ? 1 : len;
        k = 0; cyc = 0; lowrun = -1; prev_stall = 0;
        prev_data = '0; prev_last = 1'b0; dones = 0;
        @(negedge clk);
        pkt_len = 16'(len); gap_len = 8'(gap); num_pkts = 16'(n);
        enable = 1'b1; m_axis_tready = 1'b0;
        @(negedge clk);
        chk("start_latency_tvalid", 64'(m_axis_tvalid), 64'd1);
        while (busy && cyc < 3000) begin
            if (done) begin
                dones++;
                chk("pkt_count_at_done", 64'(pkt_count), 64'(n));
                enable = 1'b0;
            end
            if (prev_stall) begin
                chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
                chk("stall_tdata", m_axis_tdata, prev_data);
                chk("stall_tlast", 64'(m_axis_tlast), 64'(prev_last));
            end
            if (m_axis_tvalid) begin
                if (lowrun >= 0) begin
                    chk("gap_cycles", 64'(lowrun), 64'(gap));
                    lowrun = -1;
                end
                chk("tdata", m_axis_tdata, 64'(k));
                chk("tlast", 64'(m_axis_tlast), 64'((k % lw) == lw - 1));
            end else if (lowrun >= 0) begin
                lowrun++;
            end
            m_axis_tready = rnd != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_axis_tvalid && m_axis_tready) begin
                if (k == drop_at) enable = 1'b0;
                if (m_axis_tlast) lowrun = 0;
                k++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            // Config changes while busy must be ignored.
            pkt_len  = 16'($urandom_range(0, 9));
            gap_len  = 8'($urandom_range(0, 5));
            num_pkts = 16'($urandom_range(0, 9));
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc >= 3000) begin
            n_bad++;
            $display("FAIL run_timeout: busy still %0b after %0d cycles", busy, cyc);
        end
        enable = 1'b0;
        chk("idle_tvalid", 64'(m_axis_tvalid), 64'd0);
        words = k;
        pkts  = int'(pkt_count);
    endtask

    vec_t vecs[5];

    initial begin
        int w;
        int p;
        int d;
        int k;
        vecs[0] = '{4, 0, 2, 0, -1, 8, 2, 1};
        vecs[1] = '{3, 2, 3, 0, -1, 9, 3, 1};
        vecs[2] = '{5, 0, 1, 1, -1, 5, 1, 1};
        vecs[3] = '{0, 0, 3, 0, -1, 3, 3, 1};
        vecs[4] = '{8, 0, 0, 0,  2, 8, 1, 0};

        rst = 1'b1; enable = 1'b0; pkt_len = '0; gap_len = '0; num_pkts = '0;
        m_axis_tready = 1'b0;
        #1;
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata", m_axis_tdata, 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_case(vecs[i].len, vecs[i].gap, vecs[i].n, vecs[i].rnd, vecs[i].drop_at, w, p, d);
            chk($sformatf("vec%0d_words", i), 64'(w), 64'(vecs[i].exp_words));
            chk($sformatf("vec%0d_pkt_count", i), 64'(p), 64'(vecs[i].exp_pkts));
            chk($sformatf("vec%0d_done_pulses", i), 64'(d), 64'(vecs[i].exp_done));
        end

        for (int r = 0; r < 6; r++) begin
            int len;
            int gap;
            int n;
            len = $urandom_range(0, 6);
            gap = $urandom_range(0, 3);
            n   = $urandom_range(1, 4);
            run_case(len, gap, n, 1, -1, w, p, d);
            chk("rnd_words", 64'(w), 64'(n * ((len == 0) ? 1 : len)));
            chk("rnd_pkt_count", 64'(p), 64'(n));
            chk("rnd_done_pulses", 64'(d), 64'd1);
        end

        // Reset during beat 2 of a 6-beat packet, then restart from word 0.
        @(negedge clk);
        pkt_len = 16'd6; gap_len = 8'd0; num_pkts = 16'd0;
        enable = 1'b1; m_axis_tready = 1'b1;
        k = 0;
        while (!(m_axis_tvalid && m_axis_tdata == 64'd2) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("mid_rst_reached_beat2", m_axis_tdata, 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("mid_rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_pkt_count", 64'(pkt_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("restart_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("restart_tdata", m_axis_tdata, 64'd0);
        enable = 1'b0;
        k = 0;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("restart_drain_idle", 64'(busy), 64'd0);
        chk("restart_pkt_count", 64'(pkt_count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
